// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: credit-limited in-order memory reads feeding a decode-side FIFO.
// Optional INST_FETCHQ_BYPASS_EN forwards a kept response straight to out_* when the queue is empty.
module inst_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              reset_pc,
  output logic                     mem_req_valid,
  output logic [31:0]              mem_req_addr,
  input  logic                     mem_req_ack,
  input  logic                     mem_rsp_valid,
  input  logic [31:0]              mem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [TW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic          run_q;
  logic [31:0]   tag_q   [MAX_OUTST];
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];

  logic credit_ok, req_fire, rsp_fire, rsp_keep, push, pop;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (32'(p) == MAX_OUTST - 1) ? '0 : p + TW'(1);
  endfunction

  // Credits depend only on registered state, so responses never reach mem_req_valid.
  assign credit_ok     = (32'(count_q) + 32'(outst_q) < DEPTH) && (32'(outst_q) < MAX_OUTST);
  assign mem_req_valid = run_q && !reset && !redirect_valid && credit_ok;
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ack;
  assign rsp_fire      = mem_rsp_valid && (outst_q != '0);
  assign rsp_keep      = rsp_fire && (drop_q == '0) && !redirect_valid;
  assign occupancy     = count_q;

`ifdef INST_FETCHQ_BYPASS_EN
  logic bypass;
  assign bypass    = rsp_keep && (count_q == '0);
  assign out_valid = ((count_q != '0) || bypass) && !redirect_valid;
  assign out_pc    = bypass ? tag_q[tag_rd_q] : pc_q[rd_ptr_q];
  assign out_instr = bypass ? mem_rsp_data : instr_q[rd_ptr_q];
  assign push      = rsp_keep && !(bypass && out_ready);
  assign pop       = out_valid && out_ready && !bypass;
`else
  assign out_valid = (count_q != '0) && !redirect_valid;
  assign out_pc    = pc_q[rd_ptr_q];
  assign out_instr = instr_q[rd_ptr_q];
  assign push      = rsp_keep;
  assign pop       = out_valid && out_ready;
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    drop_d     = drop_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    outst_d    = outst_q + OW'(req_fire) - OW'(rsp_fire);
    tag_wr_d   = req_fire ? tag_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d   = rsp_fire ? tag_inc(tag_rd_q) : tag_rd_q;
    if (redirect_valid) begin
      // Every read still in flight after this edge belongs to the old path.
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      drop_d     = outst_q + OW'(req_fire) - OW'(rsp_fire);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      count_d = count_q + CW'(push) - CW'(pop);
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= reset_pc;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      run_q      <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTST); i++) tag_q[i] <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      run_q      <= 1'b1;
      if (req_fire) tag_q[tag_wr_q] <= fetch_pc_q;
      if (push) begin
        pc_q[wr_ptr_q]    <= tag_q[tag_rd_q];
        instr_q[wr_ptr_q] <= mem_rsp_data;
      end
    end
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter MAX_OUTST, default 2, meaning maximum outstanding memory reads (1..DEPTH).
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-004 SHALL have reset_pc in 32, fetch start address loaded at reset.
REQ-005 SHALL have mem_req_valid out 1, mem_req_addr out 32, and mem_req_ack in 1; a request is accepted when valid and ack are both high.
REQ-006 SHALL have mem_rsp_valid in 1 and mem_rsp_data in 32; responses return in request order, at any latency of 1 cycle or more.
REQ-007 SHALL have redirect_valid in 1 and redirect_pc in 32, a branch/jump redirect from the execute or mem stage.
REQ-008 SHALL have out_valid out 1, out_pc out 32, out_instr out 32, and out_ready in 1, forming the decode-side handshake.
REQ-009 SHALL have occupancy out $clog2(DEPTH)+1, the current queue entry count.

Function
REQ-010 SHALL keep fetch_pc and issue mem_req_addr=fetch_pc; fetch_pc advances by 4 on each accepted request, wrapping modulo 2^32.
REQ-011 SHALL assert mem_req_valid only when all hold: count+outstanding<DEPTH; outstanding<MAX_OUTST; !redirect_valid; !reset.
REQ-012 SHALL hold mem_req_addr stable while mem_req_valid=1 and mem_req_ack=0, unless a redirect occurs.
REQ-013 SHALL record each accepted request's PC in an in-order tag FIFO of MAX_OUTST entries.
REQ-014 SHALL handle a response with drop_cnt=0 as follows: pop the tag and write {tag, mem_rsp_data} to the queue tail; outstanding decrements.
REQ-015 SHALL handle a response with drop_cnt>0 as follows: discard it, pop the tag, and decrement both drop_cnt and outstanding.
REQ-016 SHALL drive out_valid=(count>0)&&!redirect_valid; the entry pops when out_valid&&out_ready.
REQ-017 SHALL drive out_pc/out_instr from the head entry and hold them stable while out_valid&&!out_ready.
REQ-018 SHALL allow push and pop in the same cycle, including when the queue is full; the credit rule in REQ-011 guarantees a push never overflows.
REQ-019 SHALL apply the following on redirect_valid: at the next edge count=0, fetch_pc=redirect_pc, drop_cnt=outstanding+accepted_this_cycle-rsp_this_cycle, and any response that cycle is discarded.
REQ-020 SHALL resume requests from redirect_pc in the cycle after the redirect.
REQ-021 SHALL make the last redirect win on back-to-back redirects; drop_cnt accumulates correctly across them.
REQ-022 SHALL ignore mem_rsp_valid when outstanding=0, with no state change.
REQ-023 SHALL keep no combinational path from mem_rsp_* to mem_req_valid.

Reset
REQ-024 SHALL set the following while reset=1 at an edge: fetch_pc=reset_pc; count, outstanding, drop_cnt, and read/write pointers=0.
REQ-025 SHALL drive mem_req_valid=0, out_valid=0, occupancy=0 during reset and in the first cycle after; out_pc/out_instr reset to 0.
REQ-026 SHALL discard all queue contents and in-flight tracking on reset mid-operation; the memory system SHALL be reset in the same cycle and return no responses for pre-reset requests.

Configuration
REQ-027 SHALL support macro INST_FETCHQ_BYPASS_EN.
REQ-028 SHALL, when INST_FETCHQ_BYPASS_EN is defined, present a kept response combinationally on out_* in the same cycle when count=0; if out_ready=1 it is consumed without being written.
REQ-029 SHALL, when INST_FETCHQ_BYPASS_EN is undefined, always write responses to the queue; out_valid rises one cycle after mem_rsp_valid, and out_* are driven only from registers.

Verification
REQ-030 SHALL cover reset sequencing: reset_pc=0x0000_1000, ack=1, latency 1, out_ready=1 -> requests 0x1000,0x1004,0x1008...; out_pc matches in order; out_instr equals returned data.
REQ-031 SHALL cover backpressure: out_ready=0, ack=1 -> exactly DEPTH=4 requests issue, occupancy=4, mem_req_valid low; one pop -> exactly one new request.
REQ-032 SHALL cover redirect with in-flight reads: 2 requests in flight, redirect_pc=0x2000 -> next 2 responses dropped, first out_pc=0x2000, no stale instruction emitted.
REQ-033 SHALL cover simultaneous events: a redirect in the same cycle as a response and out_ready pop -> response discarded, occupancy=0 next cycle, next request addr 0x2000.
REQ-034 SHALL cover address wrap: reset_pc=0xFFFF_FFFC -> second request addr 0x0000_0000.
REQ-035 SHALL cover the bypass macro: empty queue, response data 0x0000_0013 with out_ready=1 -> with INST_FETCHQ_BYPASS_EN, out_valid and out_instr=0x13 the same cycle and occupancy stays 0; without it, they appear one cycle later.
